// File: rtl/axil_pkg.sv
// Shared types and address helpers for the AXI4-Lite to split-port SRAM bridge.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WRITE,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    // Byte address to word address; caller truncates to the SRAM address width.
    function automatic logic [63:0] word_addr(input logic [63:0] addr, input int ofs_w);
        return addr >> ofs_w;
    endfunction

    // True when any address bit above the SRAM word range is set.
    function automatic logic addr_oob(input logic [63:0] addr, input int ofs_w,
                                      input int sram_addr_w);
        return (addr >> (ofs_w + sram_addr_w)) != 64'd0;
    endfunction

endpackage

// File: rtl/axil_sram_rd_path.sv
// Read channel engine: AR handshake, SRAM port A strobe, rdata capture, R response.
module axil_sram_rd_path
    import axil_pkg::*;
#(
    parameter int SRAM_ADDR_W = 10,
    parameter int DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SRAM_ADDR_W-1:0] ar_word,
    input  logic                   ar_err,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [DATA_W-1:0]      s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic                   a_en,
    output logic                   a_re,
    output logic [SRAM_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]      a_rdata,
    input  logic                   a_rvalid
);

    rd_state_e              state;
    rd_state_e              state_nxt;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic                   err_q;
    logic [DATA_W-1:0]      rdata_q;
    logic                   ar_hs;

    assign s_arready = (state == R_IDLE) && !rst;
    assign ar_hs     = s_arvalid && s_arready;
    assign a_addr    = addr_q;
    assign s_rdata   = rdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= R_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Hold the request and capture return data; error reads return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                addr_q <= ar_word;
                err_q  <= ar_err;
            end
            if (state == R_ISSUE && err_q) begin
                rdata_q <= '0;
            end
            if (state == R_WAIT && a_rvalid) begin
                rdata_q <= a_rdata;
            end
        end
    end

    // Next state and port A / R channel outputs.
    always_comb begin
        state_nxt = state;
        a_en      = 1'b0;
        a_re      = 1'b0;
        s_rvalid  = 1'b0;
        s_rresp   = OKAY;
        case (state)
            R_IDLE: begin
                if (ar_hs) state_nxt = R_ISSUE;
            end
            R_ISSUE: begin
                a_en      = !err_q;
                a_re      = !err_q;
                state_nxt = err_q ? R_RESP : R_WAIT;
            end
            R_WAIT: begin
                if (a_rvalid) state_nxt = R_RESP;
            end
            R_RESP: begin
                s_rvalid = 1'b1;
                s_rresp  = err_q ? SLVERR : OKAY;
                if (s_rready) state_nxt = R_IDLE;
            end
            default: state_nxt = R_IDLE;
        endcase
    end

endmodule

// File: rtl/axil_sram_bridge.sv
// AXI4-Lite responder in front of a split-port word SRAM (A = read, B = write).
// Optional feature: define AXIL_SRAM_BRIDGE_SLVERR_EN to answer SLVERR (and skip
// the SRAM strobe) for addresses with bits set above the SRAM word range.
module axil_sram_bridge
    import axil_pkg::*;
#(
    parameter int AXI_ADDR_W  = 16,
    parameter int SRAM_ADDR_W = 10,
    parameter int DATA_W      = 32,
    parameter int BYTE_W      = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXI_ADDR_W-1:0]  s_awaddr,
    input  logic                   s_awvalid,
    output logic                   s_awready,
    input  logic [DATA_W-1:0]      s_wdata,
    input  logic [BYTE_W-1:0]      s_wstrb,
    input  logic                   s_wvalid,
    output logic                   s_wready,
    output logic [1:0]             s_bresp,
    output logic                   s_bvalid,
    input  logic                   s_bready,
    input  logic [AXI_ADDR_W-1:0]  s_araddr,
    input  logic                   s_arvalid,
    output logic                   s_arready,
    output logic [DATA_W-1:0]      s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rvalid,
    input  logic                   s_rready,
    output logic                   a_en,
    output logic                   a_re,
    output logic [SRAM_ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0]      a_rdata,
    input  logic                   a_rvalid,
    output logic                   b_en,
    output logic                   b_we,
    output logic [SRAM_ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0]      b_wdata,
    output logic [BYTE_W-1:0]      b_wmask
);

    localparam int OFS_W = $clog2(BYTE_W);

    logic [SRAM_ADDR_W-1:0] aw_word;
    logic [SRAM_ADDR_W-1:0] ar_word;
    logic                   aw_err;
    logic                   ar_err;

    assign aw_word = SRAM_ADDR_W'(word_addr(64'(s_awaddr), OFS_W));
    assign ar_word = SRAM_ADDR_W'(word_addr(64'(s_araddr), OFS_W));

`ifdef AXIL_SRAM_BRIDGE_SLVERR_EN
    assign aw_err = addr_oob(64'(s_awaddr), OFS_W, SRAM_ADDR_W);
    assign ar_err = addr_oob(64'(s_araddr), OFS_W, SRAM_ADDR_W);
`else
    assign aw_err = 1'b0;
    assign ar_err = 1'b0;
`endif

    wr_state_e              wr_state;
    wr_state_e              wr_state_nxt;
    logic                   aw_held;
    logic                   w_held;
    logic                   aw_err_q;
    logic [SRAM_ADDR_W-1:0] aw_word_q;
    logic [DATA_W-1:0]      w_data_q;
    logic [BYTE_W-1:0]      w_strb_q;
    logic                   aw_hs;
    logic                   w_hs;

    assign s_awready = (wr_state == W_IDLE) && !aw_held && !rst;
    assign s_wready  = (wr_state == W_IDLE) && !w_held && !rst;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign b_addr    = aw_word_q;
    assign b_wdata   = w_data_q;
    assign b_wmask   = w_strb_q;

    // Write state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    // AW and W are captured independently; both flags drop once B is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_err_q  <= 1'b0;
            aw_word_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_word_q <= aw_word;
                aw_err_q  <= aw_err;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
            if (wr_state == W_RESP && s_bready) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    // Write next state, port B strobes and B channel.
    always_comb begin
        wr_state_nxt = wr_state;
        b_en         = 1'b0;
        b_we         = 1'b0;
        s_bvalid     = 1'b0;
        s_bresp      = OKAY;
        case (wr_state)
            W_IDLE: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) wr_state_nxt = W_WRITE;
            end
            W_WRITE: begin
                b_en         = !aw_err_q;
                b_we         = !aw_err_q;
                wr_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                s_bresp  = aw_err_q ? SLVERR : OKAY;
                if (s_bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    axil_sram_rd_path #(
        .SRAM_ADDR_W (SRAM_ADDR_W),
        .DATA_W      (DATA_W)
    ) u_rd_path (
        .clk       (clk),
        .rst       (rst),
        .ar_word   (ar_word),
        .ar_err    (ar_err),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .a_en      (a_en),
        .a_re      (a_re),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid)
    );

endmodule

// File: tb/tb_axil_sram_bridge.sv
// Directed bench for axil_sram_bridge with a behavioural 2-cycle-latency SRAM.
module tb_axil_sram_bridge;

`ifdef AXIL_SRAM_BRIDGE_SLVERR_EN
    localparam logic SLV = 1'b1;
`else
    localparam logic SLV = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [15:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        a_en;
    logic        a_re;
    logic [9:0]  a_addr;
    logic [31:0] a_rdata;
    logic        a_rvalid;
    logic        b_en;
    logic        b_we;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wmask;

    int n_cmp;
    int n_err;

    axil_sram_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .a_en      (a_en),
        .a_re      (a_re),
        .a_addr    (a_addr),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_en      (b_en),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_wmask   (b_wmask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write commits first, read sampled after it, data 2 cycles later.
    logic [31:0] mem [0:1023];
    logic        v_p1, v_p2, inj;
    logic [31:0] d_p1, d_p2;
    int          a_cnt, b_cnt;

    always @(posedge clk) begin
        if (b_en && b_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b_wmask[i]) mem[b_addr][8*i +: 8] = b_wdata[8*i +: 8];
            end
        end
        v_p1 <= a_en && a_re;
        d_p1 <= mem[a_addr];
        v_p2 <= v_p1;
        d_p2 <= d_p1;
        if (a_en) a_cnt <= a_cnt + 1;
        if (b_en) b_cnt <= b_cnt + 1;
    end

    assign a_rvalid = v_p2 || inj;
    assign a_rdata  = inj ? 32'hBAD0BAD0 : d_p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // AW and W in the same cycle; bready raised once the write strobe is seen.
    task automatic axi_write(input string tag, input logic [15:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [9:0] exp_word, input logic err);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        check({tag, "_awready"}, 32'(s_awready), 32'd1);
        check({tag, "_wready"}, 32'(s_wready), 32'd1);
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        check({tag, "_b_en"}, 32'(b_en), 32'(!err));
        check({tag, "_b_addr"}, 32'(b_addr), 32'(exp_word));
        check({tag, "_b_wmask"}, 32'(b_wmask), 32'(strb));
        check({tag, "_bvalid_t1"}, 32'(s_bvalid), 32'd0);
        s_bready = 1'b1;
        step();
        check({tag, "_bvalid_t2"}, 32'(s_bvalid), 32'd1);
        check({tag, "_bresp"}, 32'(s_bresp), err ? 32'd2 : 32'd0);
        step();
        s_bready = 1'b0;
        check({tag, "_bvalid_done"}, 32'(s_bvalid), 32'd0);
    endtask

    // Read with exact-latency checks; error reads answer two cycles after AR.
    task automatic axi_read(input string tag, input logic [15:0] addr, input logic [9:0] exp_word,
                            input logic [31:0] exp_data, input logic err);
        s_araddr = addr; s_arvalid = 1'b1;
        check({tag, "_arready"}, 32'(s_arready), 32'd1);
        step();
        s_arvalid = 1'b0;
        check({tag, "_a_en"}, 32'(a_en), 32'(!err));
        check({tag, "_a_addr"}, 32'(a_addr), 32'(exp_word));
        if (!err) begin
            step();
            check({tag, "_rvalid_t2"}, 32'(s_rvalid), 32'd0);
            step();
            check({tag, "_rvalid_t3"}, 32'(s_rvalid), 32'd0);
        end
        step();
        check({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
        check({tag, "_rdata"}, s_rdata, exp_data);
        check({tag, "_rresp"}, 32'(s_rresp), err ? 32'd2 : 32'd0);
        s_rready = 1'b1;
        step();
        s_rready = 1'b0;
        check({tag, "_rvalid_done"}, 32'(s_rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int a0, b0;
        n_cmp = 0; n_err = 0; a_cnt = 0; b_cnt = 0; inj = 1'b0;
        rst = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        step();
        step();
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_strobes", {28'd0, a_en, a_re, b_en, b_we}, 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        rst = 1'b0;
        step();

        // Basic write then read.
        axi_write("wr10", 16'h0010, 32'hDEADBEEF, 4'hF, 10'd4, 1'b0);
        axi_read("rd10", 16'h0010, 10'd4, 32'hDEADBEEF, 1'b0);

        // W three cycles ahead of AW, single byte lane.
        s_wdata = 32'h0000AB00; s_wstrb = 4'h2; s_wvalid = 1'b1;
        check("wfirst_wready", 32'(s_wready), 32'd1);
        step();
        s_wvalid = 1'b0;
        check("wfirst_wready_held", 32'(s_wready), 32'd0);
        check("wfirst_awready", 32'(s_awready), 32'd1);
        step();
        check("wfirst_no_b_en", 32'(b_en), 32'd0);
        step();
        s_awaddr = 16'h0010; s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        check("wfirst_b_en", 32'(b_en), 32'd1);
        check("wfirst_wmask", 32'(b_wmask), 32'h2);
        s_bready = 1'b1;
        step();
        check("wfirst_bvalid", 32'(s_bvalid), 32'd1);
        step();
        s_bready = 1'b0;
        axi_read("rdmerge", 16'h0010, 10'd4, 32'hDEADABEF, 1'b0);

        // Zero strobe is a no-op; misaligned read aliases to the same word.
        axi_write("wr_zero", 16'h0010, 32'hFFFFFFFF, 4'h0, 10'd4, 1'b0);
        axi_read("rd_mis", 16'h0013, 10'd4, 32'hDEADABEF, 1'b0);

        // Backpressure on B, new AW/W offered meanwhile.
        s_awaddr = 16'h0020; s_awvalid = 1'b1;
        s_wdata = 32'h12345678; s_wstrb = 4'hF; s_wvalid = 1'b1;
        step();
        s_awaddr = 16'h0030; s_wdata = 32'h99999999;
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", 32'(s_bvalid), 32'd1);
            check("stall_bresp", 32'(s_bresp), 32'd0);
            check("stall_awready", 32'(s_awready), 32'd0);
            check("stall_wready", 32'(s_wready), 32'd0);
            step();
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
        step();
        s_bready = 1'b0;
        check("stall_bdone", 32'(s_bvalid), 32'd0);

        // Backpressure on R, new AR offered meanwhile.
        s_araddr = 16'h0020; s_arvalid = 1'b1;
        step();
        s_araddr = 16'h0030;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid", 32'(s_rvalid), 32'd1);
            check("stall_rdata", s_rdata, 32'h12345678);
            check("stall_arready", 32'(s_arready), 32'd0);
            step();
        end
        s_arvalid = 1'b0; s_rready = 1'b1;
        step();
        s_rready = 1'b0;
        check("stall_rdone", 32'(s_rvalid), 32'd0);

        // Write and read of word 7 whose W_WRITE and R_ISSUE coincide.
        s_awaddr = 16'h001C; s_awvalid = 1'b1;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 16'h001C; s_arvalid = 1'b1;
        step();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        check("same_b_en", 32'(b_en), 32'd1);
        check("same_a_en", 32'(a_en), 32'd1);
        s_bready = 1'b1; s_rready = 1'b1;
        step();
        check("same_bvalid", 32'(s_bvalid), 32'd1);
        step();
        step();
        check("same_rvalid", 32'(s_rvalid), 32'd1);
        check("same_rdata", s_rdata, 32'hCAFEF00D);
        step();
        s_bready = 1'b0; s_rready = 1'b0;

        // Upper address bits: SLVERR with the feature, aliasing to word 0 without.
        axi_write("wr0", 16'h0000, 32'h11111111, 4'hF, 10'd0, 1'b0);
        a0 = a_cnt; b0 = b_cnt;
        axi_write("wr1000", 16'h1000, 32'h55AA55AA, 4'hF, 10'd0, SLV);
        axi_read("rd1000", 16'h1000, 10'd0, SLV ? 32'h0 : 32'h55AA55AA, SLV);
        check("oob_a_cnt", 32'(a_cnt - a0), SLV ? 32'd0 : 32'd1);
        check("oob_b_cnt", 32'(b_cnt - b0), SLV ? 32'd0 : 32'd1);
        axi_read("rd0", 16'h0000, 10'd0, SLV ? 32'h11111111 : 32'h55AA55AA, 1'b0);

        // Reset while waiting on port A, then a stray a_rvalid.
        s_araddr = 16'h0010; s_arvalid = 1'b1;
        step();
        s_arvalid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mrst_arready", 32'(s_arready), 32'd0);
        check("mrst_rvalid", 32'(s_rvalid), 32'd0);
        check("mrst_a_en", 32'(a_en), 32'd0);
        a0 = a_cnt;
        step();
        step();
        rst = 1'b0;
        step();
        inj = 1'b1;
        step();
        inj = 1'b0;
        check("stray_rvalid", 32'(s_rvalid), 32'd0);
        check("stray_arready", 32'(s_arready), 32'd1);
        step();
        check("stray_rvalid2", 32'(s_rvalid), 32'd0);
        check("stray_a_cnt", 32'(a_cnt - a0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
